spi_master_multi: RTL and testbench

Parametrised full-duplex SPI master, successor to the fixed 8-bit single-slave master. It supports any data width, a programmable SCLK divider, and all four CPOL/CPHA modes latched per transfer. It drives NUM_SS one-hot active-low slave selects and shifts TX and RX simultaneously. It sits between a register/bus front-end (start/ready/done handshake) and the board-level SPI pins.

---
 rtl/spi_master_multi.sv | 104 ++++++++++
 tb/tb_spi_master_multi.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: full-duplex SPI master (any width, CPOL/CPHA per transfer, NUM_SS one-hot selects); SPI_MASTER_MULTI_LSB_FIRST_EN adds lsb_first
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int CLK_DIV = 10,
  parameter int NUM_SS = 4,
  localparam int SSW = NUM_SS > 1 ? $clog2(NUM_SS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SSW-1:0]    ss_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              ready,
  output logic              done
);
  localparam int DVW = $clog2(CLK_DIV);
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;
  state_t state, state_nx;
  logic [DVW-1:0] div;
  logic [EW-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, tx_load;
  logic cpha_s, lsb_s, lsb_in, accept, wrap, tick, lead, last, shift_ev, sample_ev, out_bit, timed;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif
  assign ready = state == IDLE;
  assign accept = start && ready;
  assign timed = state == SETUP || state == TRANSFER || state == HOLD;
  assign wrap = div == DVW'(CLK_DIV - 1);
  assign tick = state == TRANSFER && wrap;
  assign lead = !edge_cnt[0];
  assign last = edge_cnt == EW'(2 * DATA_W - 1);
  // the final trailing edge of CPHA=0 leaves the last bit on mosi through HOLD
  assign shift_ev = tick && (cpha_s ? lead : !lead && !last);
  assign sample_ev = tick && (cpha_s ? !lead : lead);
  assign out_bit = lsb_s ? tx_sr[0] : tx_sr[DATA_W-1];
  assign tx_load = lsb_in ? tx_data >> 1 : tx_data << 1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = SETUP;
      SETUP:    if (wrap) state_nx = TRANSFER;
      TRANSFER: if (wrap && last) state_nx = HOLD;
      HOLD:     if (wrap) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      edge_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cpha_s <= 1'b0;
      lsb_s <= 1'b0;
      mosi <= 1'b0;
      sclk <= 1'b0;
      ss_n <= '1;
      rx_data <= '0;
      done <= 1'b0;
    end else begin
      div <= timed && !wrap ? div + DVW'(1) : '0;
      done <= state == HOLD && wrap;
      if (state == IDLE) sclk <= cpol;
      if (tick) begin
        sclk <= ~sclk;
        edge_cnt <= last ? '0 : edge_cnt + EW'(1);
      end
      if (accept) begin
        cpha_s <= cpha;
        lsb_s <= lsb_in;
        ss_n <= ~(NUM_SS'(1) << ss_sel);
        tx_sr <= cpha ? tx_data : tx_load;
        mosi <= cpha ? 1'b0 : lsb_in ? tx_data[0] : tx_data[DATA_W-1];
      end
      if (shift_ev) begin
        mosi <= out_bit;
        tx_sr <= lsb_s ? tx_sr >> 1 : tx_sr << 1;
      end
      if (sample_ev) rx_sr <= lsb_s ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
      if (state == HOLD && wrap) begin
        rx_data <= rx_sr;
        ss_n <= '1;
        mosi <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed bench with a behavioural SPI slave for 8-bit and 16-bit masters
module tb_spi_master_multi;
  logic clock = 0, reset_n = 0, start8 = 0, start16 = 0, cpol = 0, cpha = 0, miso = 0;
  logic [7:0] tx8 = 0;
  logic [15:0] tx16 = 0;
  logic [1:0] sel8 = 0, sel16 = 0;
  logic mosi8, sclk8, ready8, done8, mosi16, sclk16, ready16, done16;
  logic [3:0] ss_n8;
  logic [2:0] ss_n16;
  logic [7:0] rx8;
  logic [15:0] rx16;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
  logic lsb_first = 0;
`endif
  int checks = 0, failures = 0;
  int ecnt = 0, rises = 0, dcnt = 0;
  logic psc = 0;
  logic [15:0] mo_sr = 0, sd = 0;
  bit w16 = 0, m_cpha = 0, m_lsb = 0;

  spi_master_multi #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(4)) u8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .tx_data(tx8), .ss_sel(sel8),
    .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .miso(miso), .mosi(mosi8), .sclk(sclk8), .ss_n(ss_n8), .rx_data(rx8),
    .ready(ready8), .done(done8));

  spi_master_multi #(.DATA_W(16), .CLK_DIV(4), .NUM_SS(3)) u16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .tx_data(tx16), .ss_sel(sel16),
    .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .miso(miso), .mosi(mosi16), .sclk(sclk16), .ss_n(ss_n16), .rx_data(rx16),
    .ready(ready16), .done(done16));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave: detects sclk edges of the selected master, captures mosi and drives miso
  always @(posedge clock) begin : slave
    logic sc, busy, mo;
    int idx, dw;
    #1;
    sc = w16 ? sclk16 : sclk8;
    busy = w16 ? !ready16 : !ready8;
    mo = w16 ? mosi16 : mosi8;
    dw = w16 ? 16 : 8;
    if (w16 ? done16 : done8) dcnt++;
    if (!busy) begin
      ecnt = 0;
      rises = 0;
      mo_sr = 0;
    end else if (sc != psc) begin
      if (sc && !psc) rises++;
      if (m_cpha ? ecnt[0] : !ecnt[0]) mo_sr = {mo_sr[14:0], mo};
      ecnt++;
    end
    psc = sc;
    idx = m_cpha ? (ecnt + 1) / 2 - 1 : ecnt / 2;
    if (idx < 0) idx = 0;
    if (idx > dw - 1) idx = dw - 1;
    miso = m_lsb ? sd[idx] : sd[dw-1-idx];
  end

  task automatic xfer(input string nm, input bit b16, input bit pol, input bit pha, input bit lsb,
                      input logic [15:0] tx, input logic [15:0] sdat, input logic [1:0] sel,
                      input logic [3:0] ss_exp, input logic [15:0] mo_exp, input int act);
    int lat, d0;
    logic [3:0] ssa;
    bit rdy;
    @(negedge clock);
    w16 = b16; cpol = pol; cpha = pha; m_cpha = pha; m_lsb = lsb; sd = sdat;
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    repeat (2) @(negedge clock);
    chk({nm, "_idle_sclk"}, b16 ? sclk16 : sclk8, pol);
    d0 = dcnt;
    if (b16) begin tx16 = tx; sel16 = sel; start16 = 1; end
    else begin tx8 = tx[7:0]; sel8 = sel; start8 = 1; end
    @(posedge clock); #1;
    start8 = 0; start16 = 0;
    lat = 0; ssa = '1; rdy = 0;
    while (!(b16 ? done16 : done8) && lat < 400) begin
      @(posedge clock); #1;
      lat++;
      ssa &= b16 ? {1'b1, ss_n16} : ss_n8;
      if (b16 ? ready16 : ready8) rdy = 1;
      if (act == 1 && lat == 20) begin cpol = !pol; cpha = !pha; tx8 = ~tx8; start8 = 1; end
      if (act == 1 && lat == 30) start8 = 0;
      if (act == 2 && lat == 30) break;
    end
    if (act == 2) begin
      reset_n = 0; #1;
      chk({nm, "_ss_n"}, ss_n8, 4'hF);
      chk({nm, "_sclk"}, sclk8, 0);
      chk({nm, "_rx"}, rx8, 0);
      chk({nm, "_ready"}, ready8, 1);
      repeat (3) @(negedge clock);
      chk({nm, "_no_done"}, dcnt - d0, 0);
      reset_n = 1;
      return;
    end
    chk({nm, "_latency"}, lat, b16 ? 136 : 72);
    chk({nm, "_rx"}, b16 ? rx16 : {8'h0, rx8}, sdat);
    chk({nm, "_ss_n"}, ssa, ss_exp);
    chk({nm, "_busy_ready"}, rdy, 0);
    chk({nm, "_done_sclk"}, b16 ? sclk16 : sclk8, pol);
    chk({nm, "_mosi"}, mo_sr, mo_exp);
    chk({nm, "_rises"}, rises, b16 ? 16 : 8);
    repeat (3) @(negedge clock);
    chk({nm, "_done_cnt"}, dcnt - d0, 1);
    chk({nm, "_rx_hold"}, b16 ? rx16 : {8'h0, rx8}, sdat);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ss_n", ss_n8, 4'hF);
    chk("rst_sclk", sclk8, 0);
    chk("rst_mosi", mosi8, 0);
    chk("rst_rx", rx8, 0);
    chk("rst_done", done8, 0);
    chk("rst_ready", ready8, 1);
    reset_n = 1;
    xfer("m0", 0, 0, 0, 0, 16'hA5, 16'h3C, 2, 4'b1011, 16'hA5, 0);
    xfer("m1", 0, 0, 1, 0, 16'hC3, 16'h81, 1, 4'b1101, 16'hC3, 0);
    xfer("m2", 0, 1, 0, 0, 16'hC3, 16'h81, 0, 4'b1110, 16'hC3, 0);
    xfer("m3", 0, 1, 1, 0, 16'hC3, 16'h81, 3, 4'b0111, 16'hC3, 0);
    xfer("poke", 0, 0, 0, 0, 16'h5A, 16'hE7, 1, 4'b1101, 16'h5A, 1);
    xfer("rst", 0, 1, 1, 0, 16'h96, 16'h69, 0, 4'b1110, 16'h96, 2);
    xfer("post", 0, 0, 0, 0, 16'h3C, 16'hA5, 2, 4'b1011, 16'h3C, 0);
    xfer("w16", 1, 0, 0, 0, 16'h8001, 16'h1234, 3, 4'hF, 16'h8001, 0);
`ifdef SPI_MASTER_MULTI_LSB_FIRST_EN
    xfer("lsb", 0, 0, 0, 1, 16'h01, 16'h80, 0, 4'b1110, 16'h80, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
